uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (CSN/WEN/DATA_IN write port, TXRDY status) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin per packet: a granted requester keeps the UART until it presents a byte flagged last.
- Sits between on-chip producers (debug console, boot loader, trace unit) and the UART TX write port, so producers never poll TXRDY themselves.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART write-port signal bundle for uart_tx_arbiter.
// The master modport is the arbiter side. The slave modport is the
// environment side, which holds the requesters and the UART.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
);
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 TXRDY;
    logic                 UART_CSN;
    logic                 UART_WEN;
    logic [7:0]           UART_DATA;
    logic [GW-1:0]        GRANT_ID;
    logic                 BUSY;

    modport master (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
        output REQ_READY, UART_CSN, UART_WEN, UART_DATA, GRANT_ID, BUSY
    );

    modport slave (
        output REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
        input  REQ_READY, UART_CSN, UART_WEN, UART_DATA, GRANT_ID, BUSY
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit write port between NUM_REQ byte-stream producers.
// A round-robin grant is issued per packet. The owner keeps the UART until it
// sends a byte flagged last. All outputs come straight from registers.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GW         = 2,
    parameter int TXRDY_WAIT = 2
) (
    input logic             CLK,
    input logic             RESET_N,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        WRITE,
        HOLD
    } state_t;

    state_t               state;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        rr_ptr;
    logic [3:0]           hold_cnt;
    logic [7:0]           data_q;
    logic                 last_q;
    logic                 sent_any;
    logic                 csn_q;
    logic                 wen_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   ready_q;

    logic                 found;
    logic [GW-1:0]        next_grant;
    logic [GW-1:0]        cand;

    // Pick the first valid requester, searching upward from rr_ptr with wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found      = 1'b0;
        next_grant = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && bus.REQ_VALID[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Packet FSM with registered UART strobes, ready strobe and grant status.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            sent_any <= 1'b0;
            csn_q    <= 1'b1;
            wen_q    <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= next_grant;
                        busy_q   <= 1'b1;
                        sent_any <= 1'b0;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (bus.TXRDY && bus.REQ_VALID[grant]) begin
                        data_q         <= bus.REQ_DATA[{grant, 3'b000} +: 8];
                        last_q         <= bus.REQ_LAST[grant];
                        csn_q          <= 1'b0;
                        wen_q          <= 1'b0;
                        ready_q[grant] <= 1'b1;
                        state          <= WRITE;
                    end else if (!sent_any && !bus.REQ_VALID[grant]) begin
                        // Owner withdrew before its first byte: release without moving rr_ptr.
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WRITE: begin
                    csn_q    <= 1'b1;
                    wen_q    <= 1'b1;
                    ready_q  <= '0;
                    sent_any <= 1'b1;
                    hold_cnt <= 4'(TXRDY_WAIT);
                    state    <= HOLD;
                end
                HOLD: begin
                    // TXRDY is ignored here; the UART may not have deasserted it yet.
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt == 4'd1) begin
                        if (last_q) begin
                            busy_q <= 1'b0;
                            rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.UART_CSN  = csn_q;
    assign bus.UART_WEN  = wen_q;
    assign bus.UART_DATA = data_q;
    assign bus.REQ_READY = ready_q;
    assign bus.GRANT_ID  = grant;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A scoreboard queue holds the
// expected (requester, byte) write order, and a negedge monitor pops it on
// every UART write strobe.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int GW         = 2;
    localparam int TXRDY_WAIT = 2;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_N;

    int   assertions = 0;
    int   failures   = 0;
    int   cyc        = 0;
    exp_t sb[$];
    int   strobe_q[$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .GW(GW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .GW        (GW),
        .TXRDY_WAIT(TXRDY_WAIT)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: one-hot ready, strobe consistency, and scoreboard pop on each write.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                assertions++;
                if ($countones(bus.REQ_READY) > 1) begin
                    failures++;
                    $display("FAIL ready_onehot: REQ_READY=%b, required at most one bit", bus.REQ_READY);
                end
                if (bus.UART_WEN === 1'b0) begin
                    strobe_q.push_back(cyc);
                    assertions++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: data=%h id=%0d, required no write", bus.UART_DATA, bus.GRANT_ID);
                    end else begin
                        e = sb.pop_front();
                        if (bus.UART_DATA !== e.data || bus.GRANT_ID !== GW'(e.id) ||
                            bus.REQ_READY !== (NUM_REQ'(1) << e.id) || bus.UART_CSN !== 1'b0 || bus.BUSY !== 1'b1) begin
                            failures++;
                            $display("FAIL write_check: data=%h id=%0d ready=%b csn=%b busy=%b, required data=%h id=%0d ready=%b csn=0 busy=1",
                                     bus.UART_DATA, bus.GRANT_ID, bus.REQ_READY, bus.UART_CSN, bus.BUSY,
                                     e.data, e.id, NUM_REQ'(1) << e.id);
                        end
                    end
                end else begin
                    assertions++;
                    if (bus.UART_CSN !== 1'b1 || bus.REQ_READY !== '0) begin
                        failures++;
                        $display("FAIL idle_strobes: csn=%b ready=%b, required csn=1 ready=0", bus.UART_CSN, bus.REQ_READY);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    // Present one byte and hold it until REQ_READY is seen (bounded).
    task automatic drive_byte(input int r, input logic [7:0] d, input logic last);
        bit got = 1'b0;
        bus.REQ_DATA[8*r +: 8] = d;
        bus.REQ_LAST[r]        = last;
        bus.REQ_VALID[r]       = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge CLK);
            if (bus.REQ_READY[r] === 1'b1) got = 1'b1;
        end
        assertions++;
        if (!got) begin
            failures++;
            $display("FAIL ready_timeout: requester %0d byte %h got no REQ_READY, required within 200 cycles", r, d);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_pkt(input int r, input int n, input logic [31:0] bytes);
        for (int i = 0; i < n; i++) drive_byte(r, bytes[8*i +: 8], (i == n - 1));
        bus.REQ_VALID[r] = 1'b0;
        bus.REQ_LAST[r]  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge CLK);
            if (sb.size() == 0 && bus.BUSY === 1'b0) done = 1'b1;
        end
        assertions++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain: %0d writes pending busy=%b, required 0 pending busy=0", name, sb.size(), bus.BUSY);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N       = 1'b0;
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.REQ_LAST  = '0;
        bus.TXRDY     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        assertions++; if (bus.UART_CSN !== 1'b1) begin failures++; $display("FAIL reset_csn: %b, required 1", bus.UART_CSN); end
        assertions++; if (bus.UART_WEN !== 1'b1) begin failures++; $display("FAIL reset_wen: %b, required 1", bus.UART_WEN); end
        assertions++; if (bus.UART_DATA !== 8'h00) begin failures++; $display("FAIL reset_data: %h, required 00", bus.UART_DATA); end
        assertions++; if (bus.REQ_READY !== '0) begin failures++; $display("FAIL reset_ready: %b, required 0000", bus.REQ_READY); end
        assertions++; if (bus.GRANT_ID !== '0) begin failures++; $display("FAIL reset_grant: %0d, required 0", bus.GRANT_ID); end
        assertions++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: %b, required 0", bus.BUSY); end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Two-byte packet: latency 2, spacing TXRDY_WAIT+2, BUSY drops after HOLD.
    task automatic test_single();
        int t0;
        strobe_q.delete();
        push_exp(0, 8'h41);
        push_exp(0, 8'h42);
        t0 = cyc;
        drive_pkt(0, 2, 32'h0000_4241);
        assertions++;
        if (strobe_q.size() != 2) begin
            failures++;
            $display("FAIL single_count: %0d strobes, required 2", strobe_q.size());
        end else begin
            assertions++;
            if (strobe_q[0] != t0 + 2 || strobe_q[1] != t0 + 2 + TXRDY_WAIT + 2) begin
                failures++;
                $display("FAIL single_timing: strobes at +%0d,+%0d, required +2,+%0d",
                         strobe_q[0] - t0, strobe_q[1] - t0, 4 + TXRDY_WAIT);
            end
        end
        while (cyc < t0 + 8) @(negedge CLK);
        assertions++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL single_busy_hold: %b, required 1", bus.BUSY); end
        @(negedge CLK);
        assertions++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL single_busy_release: %b, required 0", bus.BUSY); end
    endtask

    // After requester 0 releases, rr_ptr=1, so requester 1 wins over 0.
    task automatic test_rr_pointer();
        push_exp(1, 8'h11);
        push_exp(0, 8'h10);
        fork
            drive_pkt(0, 1, 32'h10);
            drive_pkt(1, 1, 32'h11);
        join
        wait_idle("rr_pointer");
    endtask

    task automatic test_contention();
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'hA0 + 8'(i));
        fork
            drive_pkt(0, 1, 32'hA0);
            drive_pkt(1, 1, 32'hA1);
            drive_pkt(2, 1, 32'hA2);
            drive_pkt(3, 1, 32'hA3);
        join
        wait_idle("contention");
    endtask

    task automatic test_packet_lock();
        push_exp(2, 8'h31);
        push_exp(2, 8'h32);
        push_exp(2, 8'h33);
        push_exp(0, 8'h30);
        fork
            drive_pkt(2, 3, 32'h0033_3231);
            begin
                @(posedge CLK);
                #1;
                drive_pkt(0, 1, 32'h30);
            end
        join
        wait_idle("packet_lock");
    endtask

    task automatic test_backpressure();
        int tr = 0;
        strobe_q.delete();
        bus.TXRDY = 1'b0;
        push_exp(3, 8'h5A);
        fork
            drive_pkt(3, 1, 32'h5A);
            begin
                @(posedge CLK);
                #1;
                repeat (20) begin
                    @(negedge CLK);
                    assertions++;
                    if (bus.REQ_READY !== '0 || bus.UART_WEN !== 1'b1 || bus.BUSY !== 1'b1 || bus.GRANT_ID !== GW'(3)) begin
                        failures++;
                        $display("FAIL backpressure_hold: ready=%b wen=%b busy=%b id=%0d, required 0000 1 1 3",
                                 bus.REQ_READY, bus.UART_WEN, bus.BUSY, bus.GRANT_ID);
                    end
                end
                @(posedge CLK);
                #1;
                bus.TXRDY = 1'b1;
                tr = cyc;
            end
        join
        assertions++;
        if (strobe_q.size() != 1 || strobe_q[0] != tr + 1) begin
            failures++;
            $display("FAIL backpressure_release: %0d strobes, first at +%0d, required 1 strobe at +1",
                     strobe_q.size(), (strobe_q.size() > 0) ? strobe_q[0] - tr : -1);
        end
        wait_idle("backpressure");
    endtask

    // Owner drops valid before its first byte; rr_ptr (0) must stay put.
    task automatic test_withdraw();
        strobe_q.delete();
        bus.TXRDY          = 1'b0;
        bus.REQ_DATA[15:8] = 8'h99;
        bus.REQ_LAST[1]    = 1'b1;
        bus.REQ_VALID[1]   = 1'b1;
        repeat (2) @(negedge CLK);
        assertions++;
        if (bus.BUSY !== 1'b1 || bus.GRANT_ID !== GW'(1)) begin
            failures++;
            $display("FAIL withdraw_grant: busy=%b id=%0d, required busy=1 id=1", bus.BUSY, bus.GRANT_ID);
        end
        @(posedge CLK);
        #1;
        bus.REQ_VALID[1] = 1'b0;
        bus.REQ_LAST[1]  = 1'b0;
        repeat (2) @(negedge CLK);
        assertions++;
        if (bus.BUSY !== 1'b0 || strobe_q.size() != 0) begin
            failures++;
            $display("FAIL withdraw_release: busy=%b strobes=%0d, required busy=0 strobes=0", bus.BUSY, strobe_q.size());
        end
        bus.TXRDY = 1'b1;
        push_exp(1, 8'h21);
        push_exp(3, 8'h23);
        fork
            drive_pkt(1, 1, 32'h21);
            drive_pkt(3, 1, 32'h23);
        join
        wait_idle("withdraw");
    endtask

    task automatic test_reset_mid_packet();
        bit got = 1'b0;
        push_exp(1, 8'h61);
        drive_pkt(1, 1, 32'h61);
        wait_idle("reset_pre");
        push_exp(3, 8'h77);
        bus.REQ_DATA[31:24] = 8'h77;
        bus.REQ_LAST[3]     = 1'b0;
        bus.REQ_VALID[3]    = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge CLK);
            if (bus.REQ_READY[3] === 1'b1) got = 1'b1;
        end
        assertions++;
        if (!got) begin failures++; $display("FAIL midreset_first_byte: no REQ_READY[3], required within 50 cycles"); end
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        assertions++;
        if (bus.UART_CSN !== 1'b1 || bus.UART_WEN !== 1'b1 || bus.UART_DATA !== 8'h00 ||
            bus.REQ_READY !== '0 || bus.GRANT_ID !== '0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: csn=%b wen=%b data=%h ready=%b id=%0d busy=%b, required 1 1 00 0000 0 0",
                     bus.UART_CSN, bus.UART_WEN, bus.UART_DATA, bus.REQ_READY, bus.GRANT_ID, bus.BUSY);
        end
        bus.REQ_VALID[3] = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        push_exp(0, 8'h80);
        push_exp(3, 8'h83);
        fork
            drive_pkt(0, 1, 32'h80);
            drive_pkt(3, 1, 32'h83);
        join
        wait_idle("midreset_post");
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_pointer();
        apply_reset();
        test_contention();
        test_packet_lock();
        test_backpressure();
        test_withdraw();
        test_reset_mid_packet();
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d writes never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
